// File: rtl/pipe_rca_pkg.sv
// pipe_rca_pkg: shared constants and parameter helpers for the pipelined ripple-carry adder
package pipe_rca_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_STAGES = 4;
  function automatic int slice_width(input int w, input int s);
    return (s > 0) ? w / s : 1;
  endfunction
  function automatic bit params_ok(input int w, input int s);
    return (s >= 1) && (s <= w) && (w % s == 0);
  endfunction
endpackage

// File: rtl/pipe_rca_slice.sv
// pipe_rca_slice: SW-bit combinational ripple of 1-bit full adders
//   i_a, i_b : slice operands      i_cin  : carry into bit 0
//   o_sum    : slice sum           o_cout : carry out of the slice MSB
module pipe_rca_slice #(
  parameter int SW = 4
) (
  input  logic [SW-1:0] i_a,
  input  logic [SW-1:0] i_b,
  input  logic          i_cin,
  output logic [SW-1:0] o_sum,
  output logic          o_cout
);
  logic [SW:0] w_c;
  assign w_c[0] = i_cin;
  for (genvar i = 0; i < SW; i++) begin : g_fa
    assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end
  assign o_cout = w_c[SW];
endmodule

// File: rtl/pipe_rca_adder.sv
// pipe_rca_adder: STAGES-deep pipelined ripple-carry adder with valid/ready handshake
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand handshake (a, b, cin; in_sub when PIPE_RCA_ADDER_SUB_EN)
//   out_valid/out_ready : result handshake (sum, cout, ovf)
//   PIPE_RCA_ADDER_SUB_EN adds in_sub: 1 computes a - b as a + ~b + 1, ignoring cin
module pipe_rca_adder
  import pipe_rca_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPE_RCA_ADDER_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int SW = slice_width(WIDTH, STAGES);
  if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("pipe_rca_adder: WIDTH must be a nonzero multiple of STAGES, STAGES in 1..WIDTH");
  end
  logic             w_stall;
  logic [WIDTH-1:0] w_b0;
  logic             w_c0;
`ifdef PIPE_RCA_ADDER_SUB_EN
  assign w_b0 = in_sub ? ~b : b;
  assign w_c0 = in_sub | cin;
`else
  assign w_b0 = b;
  assign w_c0 = cin;
`endif
  assign w_stall  = out_valid & ~out_ready;
  assign in_ready = ~w_stall;
  // Stage k consumes the low slice of its operand source and forwards only the
  // still-unused upper slices; the finished sum slices grow by SW per stage.
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int IW = WIDTH - k * SW;
    logic [IW-1:0]         w_a, w_b;
    logic [SW-1:0]         w_ss;
    logic [(k+1)*SW-1:0]   w_sn, r_s;
    logic                  w_c, w_v, w_co, r_c, r_v;
    if (k == 0) begin : g_src
      assign w_a  = a;
      assign w_b  = w_b0;
      assign w_c  = w_c0;
      assign w_v  = in_valid;
      assign w_sn = w_ss;
    end else begin : g_src
      assign w_a  = g_st[k-1].g_op.r_a;
      assign w_b  = g_st[k-1].g_op.r_b;
      assign w_c  = g_st[k-1].r_c;
      assign w_v  = g_st[k-1].r_v;
      assign w_sn = {w_ss, g_st[k-1].r_s};
    end
    pipe_rca_slice #(.SW(SW)) u_slice (
      .i_a    (w_a[SW-1:0]),
      .i_b    (w_b[SW-1:0]),
      .i_cin  (w_c),
      .o_sum  (w_ss),
      .o_cout (w_co)
    );
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_s <= '0;
      end else if (!w_stall) begin
        r_v <= w_v;
        r_c <= w_co;
        r_s <= w_sn;
      end
    if (k < STAGES - 1) begin : g_op
      logic [IW-SW-1:0] r_a, r_b;
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (!w_stall) begin
          r_a <= w_a[IW-1:SW];
          r_b <= w_b[IW-1:SW];
        end
    end else begin : g_last
      logic r_o;
      // carry into the MSB is recovered as a ^ b ^ sum at that bit
      always_ff @(posedge clk or posedge rst)
        if (rst) r_o <= 1'b0;
        else if (!w_stall) r_o <= w_co ^ w_a[SW-1] ^ w_b[SW-1] ^ w_ss[SW-1];
    end
  end
  assign out_valid = g_st[STAGES-1].r_v;
  assign sum       = g_st[STAGES-1].r_s;
  assign cout      = g_st[STAGES-1].r_c;
  assign ovf       = g_st[STAGES-1].g_last.r_o;
endmodule
